// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling off a clock-count
// bit timer, and a valid/ack holding register with framing-error and overrun pulses.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 870
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic          rx_m;
    logic          rx_s;
    logic [2:0]    state;
    logic [TW-1:0] timer;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic          half_hit;
    logic          full_hit;
    logic          commit;
    logic          stop_bad;

    assign half_hit = (timer == HALF_M1);
    assign full_hit = (timer == FULL_M1);
    assign commit   = (state == S_STOP) && full_hit && rx_s;
    assign stop_bad = (state == S_STOP) && full_hit && !rx_s;
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            timer <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state <= S_START;
                        timer <= '0;
                    end
                end
                S_START: begin
                    // A start bit that is high again at its midpoint is a glitch.
                    if (half_hit) begin
                        timer <= '0;
                        idx   <= '0;
                        state <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_DATA: begin
                    if (full_hit) begin
                        timer      <= '0;
                        shreg[idx] <= rx_s;
                        if (idx == 3'd7)
                            state <= S_STOP;
                        else
                            idx <= idx + 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_STOP: begin
                    if (full_hit) begin
                        timer <= '0;
                        state <= rx_s ? S_IDLE : S_BREAK;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rx_s)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            // An ack landing on the commit cycle consumes the old byte, so no overrun.
            overrun   <= commit && data_valid && !data_ack;
            if (commit) begin
                data       <= shreg;
                data_valid <= 1'b1;
            end else if (data_ack) begin
                data_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a fast 16-clock/bit instance for most scenarios
// and a default-rate instance for the reset-mid-frame case, each with an event scoreboard.
module tb_uart_rx;
    localparam int CPB_A = 16;
    localparam int CPB_B = 870;

    typedef struct {
        logic       is_err;
        logic [7:0] b;
        logic       ovr;
    } ev_t;

    logic clk = 1'b0;
    logic reset_a = 1'b1, rx_a = 1'b1, ack_a = 1'b0;
    logic reset_b = 1'b1, rx_b = 1'b1, ack_b = 1'b0;
    logic [7:0] data_a, data_b;
    logic data_valid_a, frame_err_a, overrun_a, busy_a;
    logic data_valid_b, frame_err_b, overrun_b, busy_b;

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    int commit_cyc_a = 0, commit_cyc_b = 0;
    int t0;
    ev_t qa[$];
    ev_t qb[$];
    ev_t ea, eb;
    logic pv_a = 1'b0, pv_b = 1'b0;
    logic [7:0] pd_a = '0, pd_b = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx #(.CLKS_PER_BIT(CPB_A)) u_a (
        .clk(clk), .reset(reset_a), .rx(rx_a), .data(data_a), .data_valid(data_valid_a),
        .data_ack(ack_a), .frame_err(frame_err_a), .overrun(overrun_a), .busy(busy_a)
    );

    uart_rx u_b (
        .clk(clk), .reset(reset_b), .rx(rx_b), .data(data_b), .data_valid(data_valid_b),
        .data_ack(ack_b), .frame_err(frame_err_b), .overrun(overrun_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Scoreboard monitors: a commit shows as valid rising or the held byte changing.
    always @(negedge clk) begin
        if (reset_a) begin
            pv_a = 1'b0;
            pd_a = '0;
        end else begin
            if (data_valid_a && (!pv_a || data_a != pd_a)) begin
                commit_cyc_a = cyc;
                check("a_byte_expected", 32'(qa.size() != 0), 32'd1);
                if (qa.size() != 0) begin
                    ea = qa.pop_front();
                    check("a_commit_kind", 32'(frame_err_a), 32'(ea.is_err));
                    check("a_data", 32'(data_a), 32'(ea.b));
                    check("a_overrun", 32'(overrun_a), 32'(ea.ovr));
                end
            end else if (overrun_a) begin
                check("a_stray_overrun", 32'(overrun_a), 32'd0);
            end
            if (frame_err_a) begin
                check("a_ferr_expected", 32'(qa.size() != 0), 32'd1);
                if (qa.size() != 0) begin
                    ea = qa.pop_front();
                    check("a_ferr_kind", 32'(frame_err_a), 32'(ea.is_err));
                end
            end
            pv_a = data_valid_a;
            pd_a = data_a;
        end
    end

    always @(negedge clk) begin
        if (reset_b) begin
            pv_b = 1'b0;
            pd_b = '0;
        end else begin
            if (data_valid_b && (!pv_b || data_b != pd_b)) begin
                commit_cyc_b = cyc;
                check("b_byte_expected", 32'(qb.size() != 0), 32'd1);
                if (qb.size() != 0) begin
                    eb = qb.pop_front();
                    check("b_data", 32'(data_b), 32'(eb.b));
                    check("b_overrun", 32'(overrun_b), 32'(eb.ovr));
                end
            end
            if (frame_err_b || (overrun_b && !(data_valid_b && !pv_b)))
                check("b_stray_flag", 32'(frame_err_b | overrun_b), 32'd0);
            pv_b = data_valid_b;
            pd_b = data_b;
        end
    end

    task automatic line(input int which, input logic v, input int n);
        if (which == 0) rx_a = v;
        else rx_b = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int which, input logic [7:0] b, input logic stop_v);
        int cpb;
        cpb = (which == 0) ? CPB_A : CPB_B;
        line(which, 1'b0, cpb);
        for (int i = 0; i < 8; i++) line(which, b[i], cpb);
        line(which, stop_v, cpb);
    endtask

    task automatic push_a(input logic is_err, input logic [7:0] b, input logic ovr);
        ev_t e;
        e.is_err = is_err;
        e.b = b;
        e.ovr = ovr;
        qa.push_back(e);
    endtask

    task automatic ack_pulse_a();
        ack_a = 1'b1;
        @(posedge clk);
        #1;
        ack_a = 1'b0;
    endtask

    task automatic wait_valid_a(input int budget);
        for (int i = 0; i < budget && !data_valid_a; i++) @(negedge clk);
        check("a_wait_valid", 32'(data_valid_a), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        ev_t e;
        repeat (4) @(posedge clk);
        #1;
        reset_a = 1'b0;
        reset_b = 1'b0;
        @(negedge clk);
        check("rst_data", 32'(data_a), 32'h00);
        check("rst_valid", 32'(data_valid_a), 32'd0);
        check("rst_flags", 32'({frame_err_a, overrun_a}), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_b_all", 32'({data_b, data_valid_b, frame_err_b, overrun_b, busy_b}), 32'd0);
        @(posedge clk);
        #1;

        // Single frame, exact rate, latency from pin edge to valid
        push_a(1'b0, 8'hA5, 1'b0);
        t0 = cyc;
        fork
            send(0, 8'hA5, 1'b1);
            begin
                repeat (5) @(negedge clk);
                check("a5_busy_mid", 32'(busy_a), 32'd1);
            end
        join
        check("a5_latency", 32'(commit_cyc_a - t0), 32'd155);
        check("a5_busy_after", 32'(busy_a), 32'd0);
        ack_pulse_a();
        @(negedge clk);
        check("a5_ack_clears", 32'(data_valid_a), 32'd0);
        check("a5_data_kept", 32'(data_a), 32'hA5);
        @(posedge clk);
        #1;

        // Back-to-back 0x00 / 0xFF, first acked in between
        push_a(1'b0, 8'h00, 1'b0);
        push_a(1'b0, 8'hFF, 1'b0);
        fork
            begin
                send(0, 8'h00, 1'b1);
                send(0, 8'hFF, 1'b1);
            end
            begin
                wait_valid_a(400);
                ack_pulse_a();
            end
        join
        check("b2b_data", 32'(data_a), 32'hFF);
        check("b2b_valid", 32'(data_valid_a), 32'd1);
        ack_pulse_a();

        // Overrun without ack, then ack coinciding with commit
        push_a(1'b0, 8'h3C, 1'b0);
        send(0, 8'h3C, 1'b1);
        push_a(1'b0, 8'hC3, 1'b1);
        send(0, 8'hC3, 1'b1);
        check("ovr_data", 32'(data_a), 32'hC3);
        check("ovr_valid", 32'(data_valid_a), 32'd1);
        ack_pulse_a();
        @(negedge clk);
        check("ovr_ack_clears", 32'(data_valid_a), 32'd0);
        @(posedge clk);
        #1;
        push_a(1'b0, 8'h3C, 1'b0);
        send(0, 8'h3C, 1'b1);
        push_a(1'b0, 8'hC3, 1'b0);
        fork
            send(0, 8'hC3, 1'b1);
            begin
                repeat (154) @(posedge clk);
                #1;
                ack_a = 1'b1;
                @(posedge clk);
                #1;
                ack_a = 0;
            end
        join
        check("simul_data", 32'(data_a), 32'hC3);
        check("simul_valid", 32'(data_valid_a), 32'd1);
        ack_pulse_a();

        // Short low glitch is rejected, then a real frame
        line(0, 1'b0, 5);
        line(0, 1'b1, 30);
        check("glitch_busy", 32'(busy_a), 32'd0);
        check("glitch_valid", 32'(data_valid_a), 32'd0);
        push_a(1'b0, 8'h5A, 1'b0);
        send(0, 8'h5A, 1'b1);
        check("glitch_next_valid", 32'(data_valid_a), 32'd1);
        ack_pulse_a();

        // Framing error followed by a long break
        push_a(1'b1, 8'h00, 1'b0);
        send(0, 8'h81, 1'b0);
        line(0, 1'b0, 40 * CPB_A);
        check("brk_busy_held", 32'(busy_a), 32'd1);
        check("brk_valid", 32'(data_valid_a), 32'd0);
        line(0, 1'b1, 2 * CPB_A);
        check("brk_released", 32'(busy_a), 32'd0);
        push_a(1'b0, 8'h81, 1'b0);
        send(0, 8'h81, 1'b1);
        check("brk_next_data", 32'(data_a), 32'h81);
        ack_pulse_a();

        // Default-rate instance: reset in the middle of DATA, then a clean frame
        line(1, 1'b0, CPB_B);
        line(1, 1'b1, 2 * CPB_B);
        line(1, 1'b1, CPB_B / 2);
        reset_b = 1'b1;
        @(posedge clk);
        #1;
        reset_b = 1'b0;
        @(negedge clk);
        check("b_rst_outputs", 32'({data_b, data_valid_b, frame_err_b, overrun_b, busy_b}), 32'd0);
        line(1, 1'b1, 12 * CPB_B);
        check("b_no_byte", 32'(data_valid_b), 32'd0);
        e.is_err = 1'b0;
        e.b = 8'h77;
        e.ovr = 1'b0;
        qb.push_back(e);
        t0 = cyc;
        send(1, 8'h77, 1'b1);
        check("b_latency", 32'(commit_cyc_b - t0), 32'd8268);
        check("b_valid", 32'(data_valid_b), 32'd1);
        check("b_data_final", 32'(data_b), 32'h77);

        repeat (4) @(posedge clk);
        #1;
        check("a_q_drained", 32'(qa.size()), 32'd0);
        check("b_q_drained", 32'(qb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
